// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 daisy-chain driver: register map, FSM
// state encoding and the per-device word builder.
package max7219_pkg;

  localparam logic [7:0] REG_NOOP       = 8'h00;
  localparam logic [7:0] REG_DIGIT0     = 8'h01;
  localparam logic [7:0] REG_DIGIT1     = 8'h02;
  localparam logic [7:0] REG_DIGIT2     = 8'h03;
  localparam logic [7:0] REG_DIGIT3     = 8'h04;
  localparam logic [7:0] REG_DIGIT4     = 8'h05;
  localparam logic [7:0] REG_DIGIT5     = 8'h06;
  localparam logic [7:0] REG_DIGIT6     = 8'h07;
  localparam logic [7:0] REG_DIGIT7     = 8'h08;
  localparam logic [7:0] REG_DECODE     = 8'h09;
  localparam logic [7:0] REG_INTENSITY  = 8'h0A;
  localparam logic [7:0] REG_SCAN_LIMIT = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN   = 8'h0C;
  localparam logic [7:0] REG_TEST       = 8'h0F;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_LATCH    = 3'd4
  } state_e;

  // A disabled device is handed a No-Op word so the chain length stays fixed.
  function automatic logic [15:0] dev_word(input logic       en,
                                           input logic [7:0] addr,
                                           input logic [7:0] data);
    return en ? {addr, data} : {REG_NOOP, 8'h00};
  endfunction

endpackage

// File: rtl/max7219_tick.sv
// Phase timer: 8-bit down-counter that flags the last cycle of every
// CLK_DIV-cycle phase; i_restart starts a fresh phase.
module max7219_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick,
  output logic o_pre_tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == 8'd0)) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_tick     = (r_cnt == 8'd0);
  assign o_pre_tick = (r_cnt == 8'd1);

endmodule

// File: rtl/max7219_chain.sv
// Frame sequencer for a chain of MAX7219 drivers: one LOAD-framed burst of
// 16*NUM_DEV bits, farthest device first, every output taken from a flop.
module max7219_chain
  import max7219_pkg::*;
#(
  parameter int unsigned NUM_DEV = 4,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           addr_in,
  input  logic [8*NUM_DEV-1:0] din,
  input  logic [NUM_DEV-1:0]   dev_en,
  output logic                 cs,
  output logic                 sck,
  output logic                 dout,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned      FRAME_W  = 16 * NUM_DEV;
  localparam int unsigned      BIT_W    = $clog2(FRAME_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W);
  localparam logic             DIV_ONE  = (CLK_DIV == 1);

  state_e             r_state;
  logic [FRAME_W-1:0] r_shreg;
  logic [BIT_W-1:0]   r_bit_cnt;

  logic [FRAME_W-1:0] w_frame;
  logic               w_restart;
  logic               w_tick;
  logic               w_pre_tick;
  logic               w_done_nxt;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_frame = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      w_frame[16*k +: 16] = dev_word(dev_en[k], addr_in, din[8*k +: 8]);
    end
  end

  assign w_restart = (r_state == ST_IDLE) && start;

  // done must sit in the final LATCH cycle; with a 1-cycle phase that is the entry cycle.
  assign w_done_nxt = ((r_state == ST_LATCH) && w_pre_tick) ||
                      (DIV_ONE && (r_state == ST_SHIFT_LO) && w_tick &&
                       (r_bit_cnt == LAST_BIT));

  max7219_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_restart),
    .o_tick    (w_tick),
    .o_pre_tick(w_pre_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      cs        <= 1'b1;
      sck       <= 1'b0;
      dout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      r_bit_cnt <= '0;
      // NOTE: the shift register is cleared too, so an aborted frame leaves no stale bits.
      r_shreg   <= '0;
    end else begin
      done <= w_done_nxt;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_SETUP;
            r_shreg   <= w_frame;
            dout      <= w_frame[FRAME_W-1];
            cs        <= 1'b0;
            busy      <= 1'b1;
            r_bit_cnt <= '0;
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            r_state <= ST_SHIFT_HI;
            sck     <= 1'b1;
          end
        end
        ST_SHIFT_HI: begin
          // Next bit is presented on the falling edge, giving it a full low phase of setup.
          if (w_tick) begin
            r_state   <= ST_SHIFT_LO;
            sck       <= 1'b0;
            r_shreg   <= {r_shreg[FRAME_W-2:0], 1'b0};
            dout      <= r_shreg[FRAME_W-2];
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          end
        end
        ST_SHIFT_LO: begin
          if (w_tick) begin
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= ST_LATCH;
              cs      <= 1'b1;
              dout    <= 1'b0;
            end else begin
              r_state <= ST_SHIFT_HI;
              sck     <= 1'b1;
            end
          end
        end
        ST_LATCH: begin
          if (w_tick) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max7219_chain.sv
// Scoreboard bench: three chain configurations share clk/rst; a negedge
// monitor models each MAX7219 chain and checks frames against queued stimulus.
module tb_max7219_chain;
  import max7219_pkg::*;

  typedef struct packed {
    logic [7:0]  addr;
    logic [63:0] din;
    logic [7:0]  en;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]       start_v = '0;
  logic [2:0][7:0]  addr_v  = '0;
  logic [2:0][63:0] din_v   = '0;
  logic [2:0][7:0]  en_v    = '0;
  logic [2:0]       cs_v, sck_v, dout_v, busy_v, done_v;

  int n_cmp = 0;
  int n_err = 0;

  rec_t         exp_q [3][$];
  logic         abort_v [3];
  logic         p_cs [3], p_sck [3], p_dout [3], p_busy [3];
  logic [127:0] cap [3];
  int           nbits [3];
  int           busy_cnt [3], done_cnt [3], done_at [3];
  logic [7:0]   mod_regs [3][8][16];
  logic [7:0]   exp_regs [3][8][16];

  max7219_chain #(.NUM_DEV(1), .CLK_DIV(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .addr_in(addr_v[0]),
    .din(din_v[0][7:0]), .dev_en(en_v[0][0:0]), .cs(cs_v[0]), .sck(sck_v[0]),
    .dout(dout_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  max7219_chain #(.NUM_DEV(4), .CLK_DIV(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .addr_in(addr_v[1]),
    .din(din_v[1][31:0]), .dev_en(en_v[1][3:0]), .cs(cs_v[1]), .sck(sck_v[1]),
    .dout(dout_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  max7219_chain #(.NUM_DEV(2), .CLK_DIV(2)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .addr_in(addr_v[2]),
    .din(din_v[2][15:0]), .dev_en(en_v[2][1:0]), .cs(cs_v[2]), .sck(sck_v[2]),
    .dout(dout_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  function automatic int ndev_of(input int id);
    return (id == 0) ? 1 : (id == 1) ? 4 : 2;
  endfunction

  function automatic int div_of(input int id);
    return (id == 0) ? 1 : 2;
  endfunction

  // Expected bit stream, farthest device in the top word.
  function automatic logic [127:0] exp_frame(input rec_t r, input int n);
    logic [127:0] f;
    f = '0;
    for (int k = n - 1; k >= 0; k--) begin
      f = f << 16;
      if (r.en[k]) f[15:0] = {r.addr, r.din[8*k +: 8]};
    end
    return f;
  endfunction

  task automatic mon_step(input int id, input logic cs_s, input logic sck_s,
                          input logic dout_s, input logic busy_s, input logic done_s);
    int n, d;
    rec_t r;
    logic [127:0] ef;
    logic [15:0] w;
    logic ok;
    n = ndev_of(id);
    d = div_of(id);

    n_cmp++;
    if (cs_s && (dout_s !== 1'b0)) begin
      n_err++;
      $display("FAIL dout_idle[%0d]: dout=%b with cs=1, required 0", id, dout_s);
    end
    n_cmp++;
    if (done_s && !busy_s) begin
      n_err++;
      $display("FAIL done_outside_busy[%0d]: done=1 busy=0, required done=0", id);
    end
    if (sck_s && p_sck[id]) begin
      n_cmp++;
      if (dout_s !== p_dout[id]) begin
        n_err++;
        $display("FAIL dout_stable_hi[%0d]: dout=%b during sck high, required %b", id, dout_s, p_dout[id]);
      end
    end

    if (!cs_s && p_cs[id]) begin
      cap[id]   = '0;
      nbits[id] = 0;
    end
    if (sck_s && !p_sck[id]) begin
      cap[id] = {cap[id][126:0], dout_s};
      nbits[id]++;
    end

    if (busy_s && !p_busy[id]) begin
      busy_cnt[id] = 0;
      done_cnt[id] = 0;
      done_at[id]  = 0;
    end
    if (busy_s) begin
      busy_cnt[id]++;
      if (done_s) begin
        done_cnt[id]++;
        done_at[id] = busy_cnt[id];
      end
    end
    if (!busy_s && p_busy[id] && !abort_v[id]) begin
      n_cmp++;
      if (busy_cnt[id] != (32 * n + 2) * d) begin
        n_err++;
        $display("FAIL busy_len[%0d]: busy high %0d cycles, required %0d", id, busy_cnt[id], (32 * n + 2) * d);
      end
      n_cmp++;
      if (done_cnt[id] != 1 || done_at[id] != busy_cnt[id]) begin
        n_err++;
        $display("FAIL done_pulse[%0d]: %0d pulses at busy cycle %0d, required 1 at %0d",
                 id, done_cnt[id], done_at[id], busy_cnt[id]);
      end
    end

    if (cs_s && !p_cs[id]) begin
      if (abort_v[id]) begin
        if (exp_q[id].size() > 0) void'(exp_q[id].pop_front());
        abort_v[id] = 1'b0;
      end else begin
        n_cmp++;
        if (exp_q[id].size() == 0) begin
          n_err++;
          $display("FAIL unexpected_frame[%0d]: LOAD rose with %0d bits, required no frame", id, nbits[id]);
        end else begin
          r  = exp_q[id].pop_front();
          ef = exp_frame(r, n);
          if (nbits[id] != 16 * n) begin
            n_err++;
            $display("FAIL sck_pulses[%0d]: %0d pulses, required %0d", id, nbits[id], 16 * n);
          end
          n_cmp++;
          if (cap[id] !== ef) begin
            n_err++;
            $display("FAIL frame_bits[%0d]: got %h, required %h", id, cap[id], ef);
          end
          for (int k = 0; k < n; k++) begin
            w = cap[id][16*k +: 16];
            if (w[15:8] != 8'h00 && w[15:8] < 8'h10) mod_regs[id][k][w[11:8]] = w[7:0];
            if (r.en[k] && r.addr != 8'h00 && r.addr < 8'h10)
              exp_regs[id][k][r.addr[3:0]] = r.din[8*k +: 8];
          end
          ok = 1'b1;
          for (int k = 0; k < n; k++)
            for (int a = 0; a < 16; a++)
              if (mod_regs[id][k][a] !== exp_regs[id][k][a]) ok = 1'b0;
          n_cmp++;
          if (!ok) begin
            n_err++;
            $display("FAIL device_regs[%0d]: chain model register contents differ from required", id);
          end
        end
      end
    end

    p_cs[id]   = cs_s;
    p_sck[id]  = sck_s;
    p_dout[id] = dout_s;
    p_busy[id] = busy_s;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) mon_step(i, cs_v[i], sck_v[i], dout_v[i], busy_v[i], done_v[i]);
  end

  task automatic send(input int id, input logic [7:0] a, input logic [63:0] dd, input logic [7:0] en);
    rec_t r;
    @(negedge clk);
    addr_v[id]  = a;
    din_v[id]   = dd;
    en_v[id]    = en;
    start_v[id] = 1'b1;
    r.addr = a;
    r.din  = dd;
    r.en   = en;
    exp_q[id].push_back(r);
    @(negedge clk);
    start_v[id] = 1'b0;
  endtask

  task automatic wait_done(input int id, input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done_v[id]) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout[%0d]: no done within %0d cycles, required done", id, budget);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({cs_v[i], sck_v[i], dout_v[i], busy_v[i], done_v[i]} !== 5'b10000) begin
        n_err++;
        $display("FAIL reset_outputs[%0d]: {cs,sck,dout,busy,done}=%b, required 10000", i,
                 {cs_v[i], sck_v[i], dout_v[i], busy_v[i], done_v[i]});
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    send(0, REG_SHUTDOWN, 64'h01, 8'h01);
    wait_done(0, 100);
  endtask

  task automatic test_chain();
    send(1, REG_INTENSITY, 64'h0F07_0301, 8'h0F);
    wait_done(1, 400);
  endtask

  task automatic test_dev_enable();
    send(1, REG_DIGIT0, 64'hA57E_3C99, 8'h04);
    wait_done(1, 400);
  endtask

  task automatic test_busy_ignore();
    rec_t r;
    @(negedge clk);
    addr_v[1] = REG_DIGIT3;  din_v[1] = 64'h1122_3344;  en_v[1] = 8'h0F;  start_v[1] = 1'b1;
    r.addr = REG_DIGIT3;  r.din = 64'h1122_3344;  r.en = 8'h0F;
    exp_q[1].push_back(r);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done_v[1]) break;
      din_v[1]  = {32'h0, $urandom};
      addr_v[1] = 8'($urandom_range(1, 15));
    end
    // start stays high through the done cycle: ignored there, taken in the IDLE cycle after.
    addr_v[1] = REG_DIGIT5;  din_v[1] = 64'hDEAD_BEEF;  en_v[1] = 8'h0B;
    r.addr = REG_DIGIT5;  r.din = 64'hDEAD_BEEF;  r.en = 8'h0B;
    exp_q[1].push_back(r);
    @(negedge clk);
    n_cmp++;
    if (busy_v[1] !== 1'b0) begin
      n_err++;
      $display("FAIL start_at_done: busy=%b in cycle after done, required 0", busy_v[1]);
    end
    @(negedge clk);
    n_cmp++;
    if (busy_v[1] !== 1'b1) begin
      n_err++;
      $display("FAIL start_after_done: busy=%b one cycle later, required 1", busy_v[1]);
    end
    start_v[1] = 1'b0;
    wait_done(1, 400);
  endtask

  task automatic test_reset_mid();
    bit reached;
    send(2, REG_DIGIT1, 64'h5AC3, 8'h03);
    reached = 1'b0;
    for (int c = 0; c < 300 && !reached; c++) begin
      @(negedge clk);
      #1;
      if (nbits[2] >= 20) reached = 1'b1;
    end
    n_cmp++;
    if (!reached) begin
      n_err++;
      $display("FAIL reach_bit20: only %0d bits shifted, required 20", nbits[2]);
    end
    abort_v[2] = 1'b1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({cs_v[2], sck_v[2], busy_v[2], dout_v[2]} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_abort: {cs,sck,busy,dout}=%b, required 1000",
               {cs_v[2], sck_v[2], busy_v[2], dout_v[2]});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(2, REG_DIGIT2, 64'h81E7, 8'h03);
    wait_done(2, 300);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      send(1, 8'($urandom_range(1, 8)), {32'h0, $urandom}, 8'($urandom_range(0, 15)));
      wait_done(1, 400);
    end
    for (int i = 0; i < 2; i++) begin
      send(0, 8'($urandom_range(9, 15)), {56'h0, 8'($urandom)}, 8'h01);
      wait_done(0, 100);
    end
    send(0, REG_TEST, 64'h00, 8'h00);
    wait_done(0, 100);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      abort_v[i] = 1'b0;  p_cs[i] = 1'b1;  p_sck[i] = 1'b0;  p_dout[i] = 1'b0;  p_busy[i] = 1'b0;
      cap[i] = '0;  nbits[i] = 0;  busy_cnt[i] = 0;  done_cnt[i] = 0;  done_at[i] = 0;
      for (int k = 0; k < 8; k++)
        for (int a = 0; a < 16; a++) begin
          mod_regs[i][k][a] = 8'h00;
          exp_regs[i][k][a] = 8'h00;
        end
    end
    test_reset();
    test_single();
    test_chain();
    test_dev_enable();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (exp_q[i].size() != 0) begin
        n_err++;
        $display("FAIL frames_missing[%0d]: %0d queued frames never seen, required 0", i, exp_q[i].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/max7219_chain.md
MAX7219_CHAIN -- requirements
Module: max7219_chain

Interface
REQ-001 Parameter NUM_DEV, default 4: number of daisy-chained MAX7219 devices; legal range 1..8.
REQ-002 Parameter CLK_DIV, default 2: clk cycles per sck half-period (D); legal range 1..255.
REQ-003 clk  input  1  single clock; all logic rises on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a frame; sampled only in IDLE.
REQ-006 addr_in  input  8  register address sent to every enabled device.
REQ-007 din  input  8*NUM_DEV  data bytes; din[8k+7:8k] belongs to device k (k=0 nearest dout).
REQ-008 dev_en  input  NUM_DEV  per-device enable; a 0 bit sends No-Op (0x00,0x00) to that device.
REQ-009 cs  output  1  LOAD, active-low frame select; data latched on its rising edge.
REQ-010 sck  output  1  serial clock, idle low.
REQ-011 dout  output  1  serial data, MSB first.
REQ-012 busy  output  1  high while a frame is in progress.
REQ-013 done  output  1  one-cycle pulse on frame completion.

Function
REQ-014 start in IDLE shall capture addr_in, din and dev_en into a 16*NUM_DEV-bit shift register on that edge; busy shall rise on the next cycle.
REQ-015 start while busy shall be ignored, with no effect on the frame in progress.
REQ-016 Frame order shall be device NUM_DEV-1 first and device 0 last; each device word is {addr, data}, MSB first.
REQ-017 A device with dev_en[k]=0 shall receive the word 16'h0000.
REQ-018 State machine: IDLE -> SETUP -> SHIFT_HI <-> SHIFT_LO -> LATCH -> IDLE.
REQ-019 SETUP shall last D cycles: cs=0, sck=0, dout=frame bit 0.
REQ-020 SHIFT_HI shall last D cycles with sck=1; dout shall be held stable.
REQ-021 SHIFT_LO shall last D cycles with sck=0; dout shall update on entry to the next bit.
REQ-022 After the SHIFT_LO of bit 16*NUM_DEV-1, the FSM shall enter LATCH.
REQ-023 LATCH shall last D cycles with cs=1 and sck=0; done shall pulse in its final cycle; IDLE follows.
REQ-024 A frame shall occupy busy for exactly (32*NUM_DEV+2)*D cycles.
REQ-025 cs, sck, dout, busy and done shall be driven directly from flops, with no combinational paths from inputs.
REQ-026 The bit counter shall be ceil(log2(16*NUM_DEV+1)) bits wide; the divider counter shall be 8 bits, reloading at D-1.
REQ-027 dout shall be 0 whenever cs=1.
REQ-028 start asserted in the same cycle that done pulses shall be ignored; it is accepted on the following cycle, in IDLE.

Reset
REQ-029 rst=0 shall asynchronously force: state=IDLE, cs=1, sck=0, dout=0, busy=0, done=0, counters=0, shift register=0.
REQ-030 Reset mid-frame shall abort the frame; cs rising may latch partial data into the devices, and this is accepted behaviour.
REQ-031 After rst deasserts, the first accepted start shall produce a complete, correct frame.

Structure
REQ-032 Package max7219_pkg shall hold the register address constants: NOOP 8'h00, DIGIT0..7 8'h01..8'h08, DECODE 8'h09, INTENSITY 8'h0A, SCAN_LIMIT 8'h0B, SHUTDOWN 8'h0C, TEST 8'h0F.
REQ-033 max7219_pkg shall also hold the FSM state enumeration.
REQ-034 One sub-module, max7219_tick, shall generate the D-cycle phase tick (8-bit down-counter with restart input); all other logic resides in max7219_chain.

Verification
REQ-035 NUM_DEV=1, D=1, addr_in=8'h0C, din=8'h01, dev_en=1 -> 16 sck pulses; dout stream 0x0C01 MSB first; busy high 34 cycles; done at cycle 34.
REQ-036 NUM_DEV=4, D=2, addr_in=8'h0A, din=32'h0F070301, dev_en=4'b1111 -> 64 bits: 0A0F 0A07 0A03 0A01; busy high 260 cycles.
REQ-037 NUM_DEV=4, dev_en=4'b0100, addr_in=8'h01, din byte2=8'h7E -> words 0000, 017E, 0000, 0000.
REQ-038 start pulsed every cycle during a frame -> exactly one frame sent; next frame begins only after done.
REQ-039 rst asserted at bit 20 of a NUM_DEV=2 frame -> cs=1, sck=0, busy=0 immediately; a following start gives a full 32-bit frame.
REQ-040 Scoreboard model of a MAX7219 chain, sampling dout on sck rising and latching on cs rising -> register contents match the expected values in every scenario.
